// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : asynchronous serial receiver, 8 data bits, optional parity,
//           one or two stop bits, runtime-configurable bit period.
//
// Ports
//   clock_i          : single clock, all logic on rising edge
//   reset_i          : synchronous, active-low reset
//   serial_i         : asynchronous UART line (idle high)
//   clock_divider_i  : clock cycles per bit (D); values below 4 act as 4
//   two_stop_bits_i  : 1 = two stop bits expected
//   parity_bit_i     : 1 = parity bit follows the data bits
//   parity_even_i    : 1 = even parity, 0 = odd parity
//   data_o           : last received byte
//   data_valid_o     : one-cycle pulse when a frame completes
//   busy_o           : high whenever the receiver is not idle
//   parity_error_o   : parity status of the last frame
//   framing_error_o  : stop-bit status of the last frame
//
// FSM states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for line low (start edge); config latched on entry
//   START     | counting to mid start bit; line high there = false start
//   DATA      | sampling 8 data bits, LSB first, one per bit period
//   PARITY    | sampling the parity bit
//   STOP      | sampling one or two stop bits; last sample completes frame
//   WAIT_HIGH | last stop bit was low (break); wait for line to go high
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLOCK_DIVIDER_WIDTH = 8
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           serial_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  output logic [7:0]                     data_o,
  output logic                           data_valid_o,
  output logic                           busy_o,
  output logic                           parity_error_o,
  output logic                           framing_error_o
);

  // Counter is at least 3 bits wide so the clamp value 4 is representable.
  localparam int CW = (CLOCK_DIVIDER_WIDTH < 3) ? 3 : CLOCK_DIVIDER_WIDTH;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  logic [2:0]    r_state;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_div;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_cnt;
  logic          r_two_stop;
  logic          r_par_en;
  logic          r_par_even;
  logic          r_par_bit;
  logic          r_ferr;
  logic [7:0]    r_shift;

  logic          w_line;
  logic [CW-1:0] w_div_in;
  logic [CW-1:0] w_div_eff;
  logic          w_cnt_zero;
  logic          w_perr;
  logic          w_ferr_next;

  assign w_line      = r_sync2;
  assign w_div_in    = CW'(clock_divider_i);
  assign w_div_eff   = (w_div_in < CW'(4)) ? CW'(4) : w_div_in;
  assign w_cnt_zero  = (r_cnt == '0);
  // Odd total under even parity (or even total under odd parity) is an error.
  assign w_perr      = r_par_en & ((^{r_shift, r_par_bit}) ^ ~r_par_even);
  assign w_ferr_next = r_ferr | ~w_line;
  assign busy_o      = (r_state != S_IDLE);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_state         <= S_IDLE;
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_div           <= CW'(4);
      r_cnt           <= '0;
      r_bit_cnt       <= '0;
      r_stop_cnt      <= 1'b0;
      r_two_stop      <= 1'b0;
      r_par_en        <= 1'b0;
      r_par_even      <= 1'b0;
      r_par_bit       <= 1'b0;
      r_ferr          <= 1'b0;
      r_shift         <= '0;
      data_o          <= '0;
      data_valid_o    <= 1'b0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
    end else begin
      r_sync1      <= serial_i;
      r_sync2      <= r_sync1;
      data_valid_o <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!w_line) begin
            r_div      <= w_div_eff;
            r_two_stop <= two_stop_bits_i;
            r_par_en   <= parity_bit_i;
            r_par_even <= parity_even_i;
            // First sample lands floor(D/2) cycles after this edge.
            r_cnt      <= (w_div_eff >> 1) - CW'(1);
            r_state    <= S_START;
          end
        end

        S_START: begin
          if (w_cnt_zero) begin
            if (w_line) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt     <= r_div - CW'(1);
              r_bit_cnt <= '0;
              r_state   <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_DATA: begin
          if (w_cnt_zero) begin
            r_shift <= {w_line, r_shift[7:1]};
            r_cnt   <= r_div - CW'(1);
            if (r_bit_cnt == 3'd7) begin
              r_stop_cnt <= 1'b0;
              r_ferr     <= 1'b0;
              r_state    <= r_par_en ? S_PARITY : S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_PARITY: begin
          if (w_cnt_zero) begin
            r_par_bit <= w_line;
            r_cnt     <= r_div - CW'(1);
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_STOP: begin
          if (w_cnt_zero) begin
            if (r_two_stop && !r_stop_cnt) begin
              r_ferr     <= w_ferr_next;
              r_stop_cnt <= 1'b1;
              r_cnt      <= r_div - CW'(1);
            end else begin
              data_o          <= r_shift;
              parity_error_o  <= w_perr;
              framing_error_o <= w_ferr_next;
              data_valid_o    <= 1'b1;
              r_state         <= w_line ? S_IDLE : S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end

        S_WAIT_HIGH: begin
          if (w_line) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       serial_i;
  logic [7:0] clock_divider_i;
  logic       two_stop_bits_i;
  logic       parity_bit_i;
  logic       parity_even_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       busy_o;
  logic       parity_error_o;
  logic       framing_error_o;

  uart_rx #(.CLOCK_DIVIDER_WIDTH(8)) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .serial_i        (serial_i),
    .clock_divider_i (clock_divider_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .data_o          (data_o),
    .data_valid_o    (data_valid_o),
    .busy_o          (busy_o),
    .parity_error_o  (parity_error_o),
    .framing_error_o (framing_error_o)
  );

  always #5 clock_i = ~clock_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_rise   = 0;
  int n_high   = 0;
  logic prev_v = 1'b0;
  logic [9:0] q_exp[$];   // {data, parity_error, framing_error}
  int         q_pulse[$]; // cycle number of each valid pulse

  always @(posedge clock_i) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse pops one expected frame.
  always @(negedge clock_i) begin
    if (data_valid_o) begin
      n_high++;
      if (!prev_v) begin
        logic [9:0] e;
        n_rise++;
        q_pulse.push_back(cyc);
        if (q_exp.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q_exp.pop_front();
          check("data", 32'(data_o), 32'(e[9:2]));
          check("parity_err", 32'(parity_error_o), 32'(e[1]));
          check("framing_err", 32'(framing_error_o), 32'(e[0]));
        end
      end
    end
    prev_v = data_valid_o;
  end

  function automatic logic exp_perr(input logic [7:0] d, input logic en,
                                    input logic even, input logic pbit);
    int ones;
    if (!en) return 1'b0;
    ones = $countones({d, pbit});
    return even ? (ones % 2 == 1) : (ones % 2 == 0);
  endfunction

  task automatic drive_bit(input logic b, input int dd);
    serial_i = b;
    repeat (dd) @(negedge clock_i);
  endtask

  // Drives one frame and pushes its expected result. With scramble set,
  // the config inputs are disturbed after the start bit to prove they
  // were latched at the start edge.
  task automatic do_frame(input logic [7:0] d, input logic par_en, input logic even,
                          input logic pbit, input logic two, input logic stop_val,
                          input logic [7:0] div_in, input int dd, input logic scramble);
    clock_divider_i = div_in;
    parity_bit_i    = par_en;
    parity_even_i   = even;
    two_stop_bits_i = two;
    q_exp.push_back({d, exp_perr(d, par_en, even, pbit), ~stop_val});
    drive_bit(1'b0, dd);
    if (scramble) begin
      parity_bit_i    = ~par_en;
      parity_even_i   = ~even;
      two_stop_bits_i = ~two;
      clock_divider_i = 8'd50;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], dd);
    if (par_en) drive_bit(pbit, dd);
    drive_bit(stop_val, dd);
    if (two) drive_bit(stop_val, dd);
    clock_divider_i = div_in;
    parity_bit_i    = par_en;
    parity_even_i   = even;
    two_stop_bits_i = two;
  endtask

  task automatic wait_idle(input int max);
    bit done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      @(negedge clock_i);
      if (!busy_o) done = 1'b1;
    end
    check("idle_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    logic [7:0] s_data;
    logic s_perr, s_ferr;

    reset_i = 1'b0; serial_i = 1'b1; clock_divider_i = 8'd87;
    two_stop_bits_i = 1'b0; parity_bit_i = 1'b0; parity_even_i = 1'b0;
    repeat (5) @(negedge clock_i);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(data_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_perr", 32'(parity_error_o), 32'd0);
    check("rst_ferr", 32'(framing_error_o), 32'd0);
    reset_i = 1'b1;
    repeat (5) @(negedge clock_i);

    // 8N1 0x55, config disturbed mid-frame
    base = n_rise;
    do_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd87, 87, 1'b1);
    wait_idle(200);
    check("8n1_pulses", 32'(n_rise - base), 32'd1);

    // even parity 0xA3, parity bit 1 (error) then 0 (ok)
    do_frame(8'hA3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd87, 87, 1'b0);
    wait_idle(200);
    do_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd87, 87, 1'b0);
    wait_idle(200);
    check("parity_err_held", 32'(parity_error_o), 32'd0);
    // odd parity 0x07, parity bit 0 -> 3 ones, odd, ok
    do_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd87, 87, 1'b0);
    wait_idle(200);

    // framing error: stop low, line held low 300 more cycles
    base = n_rise;
    do_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd87, 87, 1'b0);
    repeat (300) @(negedge clock_i);
    check("break_busy", 32'(busy_o), 32'd1);
    check("break_ferr", 32'(framing_error_o), 32'd1);
    serial_i = 1'b1;
    wait_idle(20);
    check("break_pulses", 32'(n_rise - base), 32'd1);

    // 20-cycle glitch
    base = n_rise; s_data = data_o; s_perr = parity_error_o; s_ferr = framing_error_o;
    serial_i = 1'b0;
    repeat (10) @(negedge clock_i);
    check("glitch_busy", 32'(busy_o), 32'd1);
    repeat (10) @(negedge clock_i);
    serial_i = 1'b1;
    wait_idle(200);
    check("glitch_pulses", 32'(n_rise - base), 32'd0);
    check("glitch_data", 32'(data_o), 32'(s_data));
    check("glitch_perr", 32'(parity_error_o), 32'(s_perr));
    check("glitch_ferr", 32'(framing_error_o), 32'(s_ferr));

    // reset in the middle of data bit 3
    base = n_rise;
    clock_divider_i = 8'd87; parity_bit_i = 1'b0; two_stop_bits_i = 1'b0;
    drive_bit(1'b0, 87);
    drive_bit(1'b0, 87); drive_bit(1'b0, 87); drive_bit(1'b1, 87);
    drive_bit(1'b1, 40);
    reset_i = 1'b0;
    repeat (3) @(negedge clock_i);
    check("mid_rst_data", 32'(data_o), 32'h00);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ferr", 32'(framing_error_o), 32'd0);
    check("mid_rst_perr", 32'(parity_error_o), 32'd0);
    serial_i = 1'b1;
    reset_i  = 1'b1;
    repeat (10) @(negedge clock_i);
    do_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd87, 87, 1'b0);
    wait_idle(200);
    check("after_rst_pulses", 32'(n_rise - base), 32'd1);

    // back-to-back, two stop bits, no gap
    base = n_rise;
    do_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd87, 87, 1'b0);
    do_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd87, 87, 1'b0);
    wait_idle(200);
    check("b2b_pulses", 32'(n_rise - base), 32'd2);
    if (q_pulse.size() >= 2)
      check("b2b_spacing", 32'(q_pulse[q_pulse.size()-1] - q_pulse[q_pulse.size()-2]), 32'(87 * 11));

    // divider below 4 behaves as 4
    repeat (10) @(negedge clock_i);
    do_frame(8'hC9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 4, 1'b0);
    wait_idle(50);

    repeat (20) @(negedge clock_i);
    check("scoreboard_empty", 32'(q_exp.size()), 32'd0);
    check("valid_one_cycle", 32'(n_high), 32'(n_rise));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
